// File: rtl/conv_window_sched_pkg.sv
// Shared types and constants for the 3x3 window scheduler.
package conv_window_sched_pkg;

  // Handshake sequencer states: wait for a window, start the core,
  // wait for its answer, present the result.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    OUT    = 2'd3
  } state_t;

  // Result reported when the core never answers.
  localparam logic [31:0] TIMEOUT_RESULT = 32'hFFFF_FFFF;

  // Window geometry.
  localparam int WIN_SIDE    = 3;
  localparam int WIN_SIZE    = WIN_SIDE * WIN_SIDE;
  localparam int WIN_MIN_POS = WIN_SIDE - 1;  // first row/col that closes a window

  // Row-major window slots: NW = (r-2,c-2) ... SE = (r,c).
  localparam int WIN_NW = 0;
  localparam int WIN_N  = 1;
  localparam int WIN_NE = 2;
  localparam int WIN_W  = 3;
  localparam int WIN_C  = 4;
  localparam int WIN_E  = 5;
  localparam int WIN_SW = 6;
  localparam int WIN_S  = 7;
  localparam int WIN_SE = 8;

  // Row-major slot of window element (r, c), r/c in 0..WIN_SIDE-1.
  function automatic int win_idx(input int r, input int c);
    return r * WIN_SIDE + c;
  endfunction

endpackage

// File: rtl/conv_window_sched_line_buffer.sv
// One line of pixel history: single address, asynchronous read of the old
// contents and a write of the new pixel on the same clock edge, so the value
// read during an accept is always the pixel one line above.
module conv_line_buffer
  import conv_window_sched_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Read is combinational so the window can be completed in the accept cycle.
  assign rd_data_o = mem_q[addr_i];

  // Write the incoming pixel; contents are deliberately never cleared.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[addr_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/conv_window_sched.sv
// Raster-scan 3x3 window builder and start/done sequencer for the
// convolution core. One window is in flight at a time; each produces one
// 32-bit result (or a timeout marker value) on a valid/ready stream.
module conv_window_sched
  import conv_window_sched_pkg::*;
#(
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int PIX_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_sof,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [31:0]      win0,
  output logic [31:0]      win1,
  output logic [31:0]      win2,
  output logic [31:0]      win3,
  output logic [31:0]      win4,
  output logic [31:0]      win5,
  output logic [31:0]      win6,
  output logic [31:0]      win7,
  output logic [31:0]      win8,
  output logic             core_start,
  input  logic             core_done,
  input  logic [31:0]      core_ret,
  output logic [31:0]      res_data,
  output logic             res_err,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             frame_done
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT);
  localparam int N_LB = WIN_SIDE - 1;

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   cur_col;
  logic [ROW_W-1:0]   cur_row;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [31:0]        res_data_q, res_data_d;
  logic               res_err_q, res_err_d;
  logic               frame_done_q;
  logic               accept;
  logic               line_end;
  logic               frame_end;
  logic               win_fire;

  // Line buffer chain: [0] holds row r-1, [1] holds row r-2.
  logic [PIX_W-1:0]   lb_wdata [N_LB];
  logic [PIX_W-1:0]   lb_rdata [N_LB];
  // Newest column of the window, top (r-2) to bottom (r).
  logic [PIX_W-1:0]   new_col  [WIN_SIDE];
  // Two older columns per row; the third comes straight from new_col.
  logic [PIX_W-1:0]   tap_q    [WIN_SIDE][WIN_SIDE-1];
  logic [PIX_W-1:0]   win_q    [WIN_SIDE][WIN_SIDE];
  logic [31:0]        win_flat [WIN_SIZE];

  // A start-of-frame pixel is placed at (0,0) whatever the counters say.
  assign cur_col   = pix_sof ? '0 : col_q;
  assign cur_row   = pix_sof ? '0 : row_q;
  assign line_end  = (cur_col == COL_LAST);
  assign frame_end = line_end && (cur_row == ROW_LAST);

  // Held low throughout reset, then only while waiting for a window.
  assign pix_ready = reset && (state_q == IDLE);
  assign accept    = pix_valid && pix_ready;
  // Requiring col >= 2 keeps windows from straddling the line wrap.
  assign win_fire  = accept && (cur_row >= ROW_W'(WIN_MIN_POS))
                            && (cur_col >= COL_W'(WIN_MIN_POS));

  genvar gi;

  // Chain the line buffers: the pixel falling out of one line feeds the next.
  generate
    for (gi = 0; gi < N_LB; gi++) begin : g_lb
      if (gi == 0) begin : g_head
        assign lb_wdata[gi] = pix_in;
      end else begin : g_tail
        assign lb_wdata[gi] = lb_rdata[gi-1];
      end
      conv_line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
      ) u_line (
        .clk       (clk),
        .addr_i    (cur_col),
        .wr_en_i   (accept),
        .wr_data_i (lb_wdata[gi]),
        .rd_data_o (lb_rdata[gi])
      );
      assign new_col[gi] = lb_rdata[N_LB-1-gi];
    end
  endgenerate
  assign new_col[WIN_SIDE-1] = pix_in;

  // Flatten the window and zero-extend each pixel onto the 32-bit bus.
  generate
    for (gi = 0; gi < WIN_SIZE; gi++) begin : g_win_out
      assign win_flat[gi] = 32'(win_q[gi / WIN_SIDE][gi % WIN_SIDE]);
    end
  endgenerate

  assign win0 = win_flat[WIN_NW];
  assign win1 = win_flat[WIN_N];
  assign win2 = win_flat[WIN_NE];
  assign win3 = win_flat[WIN_W];
  assign win4 = win_flat[WIN_C];
  assign win5 = win_flat[WIN_E];
  assign win6 = win_flat[WIN_SW];
  assign win7 = win_flat[WIN_S];
  assign win8 = win_flat[WIN_SE];

  assign res_data   = res_data_q;
  assign res_err    = res_err_q;
  assign res_valid  = (state_q == OUT);
  assign frame_done = frame_done_q;

  // Raster position of the next pixel, advanced on every accept.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (line_end) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
        row_d = cur_row;
      end
    end
  end

  // Raster counters and the end-of-frame pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= accept && frame_end;
    end
  end

  // Slide the two older window columns along on each accepted pixel.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < WIN_SIDE; r++) begin
        tap_q[r][0] <= tap_q[r][1];
        tap_q[r][1] <= new_col[r];
      end
    end
  end

  // Capture a complete window; it stays put until the next one fires.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < WIN_SIDE; r++) begin
        for (int c = 0; c < WIN_SIDE; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (win_fire) begin
      for (int r = 0; r < WIN_SIDE; r++) begin
        win_q[r][0] <= tap_q[r][0];
        win_q[r][1] <= tap_q[r][1];
        win_q[r][2] <= new_col[r];
      end
    end
  end

  // Sequencer next state; core_start drops as soon as the core answers.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    core_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_fire) begin
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        // Only start once the core has dropped done from its last run.
        if (!core_done) begin
          state_d    = WAIT;
          wait_cnt_d = '0;
        end
      end
      WAIT: begin
        core_start = !core_done;
        if (core_done) begin
          res_data_d = core_ret;
          res_err_d  = 1'b0;
          state_d    = OUT;
        end else if (wait_cnt_q == WAIT_LAST) begin
          res_data_d = TIMEOUT_RESULT;
          res_err_d  = 1'b1;
          state_d    = OUT;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      OUT: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state, timeout counter and result holding registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench for conv_window_sched on a 4x4 image with a weights 1..9
// core model that raises done three cycles after start.
module tb_conv_window_sched;

  localparam int IMG_W   = 4;
  localparam int IMG_H   = 4;
  localparam int PIX_W   = 8;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [PIX_W-1:0] pix_in = '0;
  logic             pix_sof = 1'b0;
  logic             pix_valid = 1'b0;
  logic             pix_ready;
  logic [31:0]      win0, win1, win2, win3, win4, win5, win6, win7, win8;
  logic             core_start;
  logic             core_done;
  logic [31:0]      core_ret;
  logic [31:0]      res_data;
  logic             res_err;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic             frame_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  conv_window_sched #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .PIX_W   (PIX_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_in     (pix_in),
    .pix_sof    (pix_sof),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .win0       (win0),
    .win1       (win1),
    .win2       (win2),
    .win3       (win3),
    .win4       (win4),
    .win5       (win5),
    .win6       (win6),
    .win7       (win7),
    .win8       (win8),
    .core_start (core_start),
    .core_done  (core_done),
    .core_ret   (core_ret),
    .res_data   (res_data),
    .res_err    (res_err),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .frame_done (frame_done)
  );

  // Core model: done three cycles after start rises, cleared when start drops.
  logic        model_done = 1'b0;
  logic [31:0] model_ret  = '0;
  logic [1:0]  model_cnt  = '0;
  logic        core_hang  = 1'b0;
  logic        force_en   = 1'b0;
  logic        force_val  = 1'b0;

  assign core_done = force_en ? force_val : model_done;
  assign core_ret  = model_ret;

  always @(posedge clk) begin
    if (!core_start) begin
      model_cnt  <= '0;
      model_done <= 1'b0;
    end else if (!core_hang) begin
      if (model_cnt == 2'd2) begin
        model_done <= 1'b1;
        model_ret  <= win0 + 32'd2 * win1 + 32'd3 * win2 + 32'd4 * win3 +
                      32'd5 * win4 + 32'd6 * win5 + 32'd7 * win6 +
                      32'd8 * win7 + 32'd9 * win8;
      end else begin
        model_cnt <= model_cnt + 2'd1;
      end
    end
  end

  // Monitor: results, frame_done pulses and core_start run lengths.
  logic [31:0] res_q [$];
  logic        err_q [$];
  int          start_runs [$];
  int          run_len = 0;
  int          fd_cnt  = 0;

  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      res_q.push_back(res_data);
      err_q.push_back(res_err);
      $display("[%0t] result #%0d data=%0d (0x%08h) err=%0b",
               $time, res_q.size() - 1, res_data, res_data, res_err);
    end
    if (frame_done) fd_cnt++;
    if (core_start) begin
      run_len++;
    end else if (run_len != 0) begin
      start_runs.push_back(run_len);
      run_len = 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got time limit, required normal completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h (%0d), expected 0x%08h (%0d)",
               tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [31:0] res_at(input int i);
    return (i < res_q.size()) ? res_q[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic err_at(input int i);
    return (i < err_q.size()) ? err_q[i] : 1'bx;
  endfunction

  function automatic int run_at(input int i);
    return (i < start_runs.size()) ? start_runs[i] : -1;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_pix(input logic [PIX_W-1:0] v, input logic sof);
    int n;
    n = 0;
    pix_in    = v;
    pix_sof   = sof;
    pix_valid = 1'b1;
    @(negedge clk);
    while (!pix_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check_val("pix_ready_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic send_seq(input int first, input int step, input int n,
                          input logic sof_first);
    for (int i = 0; i < n; i++) begin
      send_pix(PIX_W'(first + i * step), sof_first && (i == 0));
    end
  endtask

  task automatic wait_results(input int base, input int n);
    int c;
    c = 0;
    while ((res_q.size() - base) < n && c < 1000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 1000) check_val("drain_timeout", 32'(res_q.size() - base), 32'(n));
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_res_valid(input string tag);
    int c;
    c = 0;
    while (!res_valid && c < 300) begin
      @(negedge clk);
      c++;
    end
    if (c >= 300) check_val(tag, 32'(res_valid), 32'd1);
  endtask

  task automatic check_results(input string tag, input int base,
                               input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3,
                               input logic [3:0] eerr);
    logic [31:0] ev [4];
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    check_val({tag, "_count"}, 32'(res_q.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("%s_data%0d", tag, i), res_at(base + i), ev[i]);
      check_val($sformatf("%s_err%0d", tag, i), 32'(err_at(base + i)),
                32'(eerr[i]));
    end
  endtask

  initial begin
    int base;
    int fdb;
    int rb;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_pix_ready",  32'(pix_ready),  32'd0);
    check_val("rst_core_start", 32'(core_start), 32'd0);
    check_val("rst_res_valid",  32'(res_valid),  32'd0);
    check_val("rst_res_err",    32'(res_err),    32'd0);
    check_val("rst_res_data",   res_data,        32'd0);
    check_val("rst_win0",       win0,            32'd0);
    check_val("rst_win8",       win8,            32'd0);
    check_val("rst_frame_done", 32'(frame_done), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Raster-index frame: 303, 348, 483, 528; frame_done only after pixel 15.
    base = res_q.size();
    fdb  = fd_cnt;
    send_seq(0, 1, 15, 1'b1);
    check_val("t1_fd_before_last", 32'(fd_cnt - fdb), 32'd0);
    send_pix(PIX_W'(15), 1'b0);
    wait_results(base, 4);
    check_results("t1", base, 32'd303, 32'd348, 32'd483, 32'd528, 4'b0000);
    check_val("t1_fd_count", 32'(fd_cnt - fdb), 32'd1);

    // All-ones frame: 45 each, core_start high exactly 3 cycles per run.
    base = res_q.size();
    rb   = start_runs.size();
    send_seq(1, 0, 16, 1'b1);
    wait_results(base, 4);
    check_results("t2", base, 32'd45, 32'd45, 32'd45, 32'd45, 4'b0000);
    check_val("t2_runs", 32'(start_runs.size() - rb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("t2_start_len%0d", i), 32'(run_at(rb + i)), 32'd3);
    end

    // Back-pressure in OUT for 5 cycles.
    base = res_q.size();
    res_ready = 1'b0;
    fork
      send_seq(0, 1, 16, 1'b1);
      begin
        wait_res_valid("t3_res_valid_timeout");
        for (int i = 0; i < 5; i++) begin
          check_val($sformatf("t3_hold_data%0d", i), res_data, 32'd303);
          check_val($sformatf("t3_hold_ready%0d", i), 32'(pix_ready), 32'd0);
          check_val($sformatf("t3_hold_start%0d", i), 32'(core_start), 32'd0);
          if (i < 4) @(negedge clk);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("t3_one_cycle_done", 32'(res_valid), 32'd0);
        check_val("t3_one_taken", 32'(res_q.size() - base), 32'd1);
      end
    join
    wait_results(base, 4);
    check_results("t3", base, 32'd303, 32'd348, 32'd483, 32'd528, 4'b0000);

    // Hung core on the first window, normal afterwards.
    base = res_q.size();
    rb   = start_runs.size();
    core_hang = 1'b1;
    fork
      send_seq(0, 1, 16, 1'b1);
      begin
        wait_res_valid("t4_res_valid_timeout");
        core_hang = 1'b0;
      end
    join
    wait_results(base, 4);
    check_results("t4", base, 32'hFFFF_FFFF, 32'd348, 32'd483, 32'd528, 4'b0001);
    check_val("t4_timeout_start_len", 32'(run_at(rb)), 32'd16);
    check_val("t4_next_start_len", 32'(run_at(rb + 1)), 32'd3);

    // Reset during WAIT, then relaunch held off by a stuck core_done.
    base = res_q.size();
    send_seq(0, 1, 11, 1'b1);
    @(posedge clk);
    #1;
    check_val("t5_in_wait_start", 32'(core_start), 32'd1);
    reset     = 1'b0;
    force_en  = 1'b1;
    force_val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("t5_rst_start", 32'(core_start), 32'd0);
    check_val("t5_rst_valid", 32'(res_valid),  32'd0);
    check_val("t5_rst_ready", 32'(pix_ready),  32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    send_seq(0, 1, 11, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val($sformatf("t5_held_start%0d", i), 32'(core_start), 32'd0);
    end
    check_val("t5_no_result", 32'(res_q.size() - base), 32'd0);
    @(posedge clk);
    #1 force_en = 1'b0;
    send_seq(11, 1, 5, 1'b0);
    wait_results(base, 4);
    check_results("t5", base, 32'd303, 32'd348, 32'd483, 32'd528, 4'b0000);

    // Start-of-frame at raster index 9 of a partial frame.
    base = res_q.size();
    fdb  = fd_cnt;
    send_seq(200, 1, 9, 1'b1);
    send_seq(0, 1, 16, 1'b1);
    wait_results(base, 4);
    check_results("t6", base, 32'd303, 32'd348, 32'd483, 32'd528, 4'b0000);
    check_val("t6_fd_count", 32'(fd_cnt - fdb), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
